// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: MEM/WB bundle layout and stage occupancy codes.
package pipe_pkg;

   localparam int MEMWB_W            = 136;
   localparam int MEMWB_RD_LSB       = 0;
   localparam int MEMWB_INSTR_LSB    = 5;
   localparam int MEMWB_PC4_LSB      = 37;
   localparam int MEMWB_RDATA_LSB    = 69;
   localparam int MEMWB_ALURES_LSB   = 101;
   localparam int MEMWB_RESSRC_LSB   = 133;
   localparam int MEMWB_REGWRITE_LSB = 135;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_HALF  = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

endpackage

// File: rtl/pipe_slot.sv
// One valid+data holding register; clear beats load, zeroing the payload.
module pipe_slot #(
   parameter int DATA_W = 136
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] d,
   output logic              valid,
   output logic [DATA_W-1:0] data
);

   logic              valid_d, valid_q;
   logic [DATA_W-1:0] data_d, data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (clear) begin
         valid_d = 1'b0;
         data_d  = '0;
      end else if (load) begin
         valid_d = 1'b1;
         data_d  = d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/elastic_pipe_stage.sv
// Elastic stage register with optional 2-entry skid, flush and stall counter.
module elastic_pipe_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = MEMWB_W,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              in_fire, out_fire;
   logic              main_load, main_clr;
   logic              skid_load, skid_clr;
   logic [DATA_W-1:0] main_din;
   logic              main_valid, skid_valid;
   logic [DATA_W-1:0] main_data, skid_data;
   logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;
   occ_e              occ;

   // Occupancy is decoded from the slot valid flops, so it stays registered.
   assign occ = skid_valid ? OCC_FULL :
                main_valid ? OCC_HALF : OCC_EMPTY;

   assign in_ready = (SKID != 0) ? (occ != OCC_FULL)
                                 : (!main_valid || out_ready);
   assign in_fire  = in_valid && in_ready;
   assign out_fire = main_valid && out_ready;

   always_comb begin
      main_load = 1'b0;
      main_clr  = 1'b0;
      skid_load = 1'b0;
      skid_clr  = 1'b0;
      main_din  = in_data;
      if (flush) begin
         main_clr = 1'b1;
         skid_clr = 1'b1;
      end else if (SKID != 0) begin
         unique case (occ)
            OCC_EMPTY: main_load = in_fire;
            OCC_HALF: begin
               main_load = in_fire && out_fire;
               skid_load = in_fire && !out_fire;
               main_clr  = out_fire && !in_fire;
            end
            OCC_FULL: begin
               main_load = out_fire;
               main_din  = skid_data;
               skid_clr  = out_fire;
            end
            default: ;
         endcase
      end else begin
         main_load = in_fire;
         main_clr  = out_fire && !in_fire;
      end
   end

   pipe_slot #(.DATA_W(DATA_W)) u_main (
      .clk   (clk),
      .reset (reset),
      .load  (main_load),
      .clear (main_clr),
      .d     (main_din),
      .valid (main_valid),
      .data  (main_data)
   );

   generate
      if (SKID != 0) begin : g_skid
         pipe_slot #(.DATA_W(DATA_W)) u_skid (
            .clk   (clk),
            .reset (reset),
            .load  (skid_load),
            .clear (skid_clr),
            .d     (in_data),
            .valid (skid_valid),
            .data  (skid_data)
         );
      end else begin : g_noskid
         assign skid_valid = 1'b0;
         assign skid_data  = '0;
      end
   endgenerate

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (main_valid && !out_ready && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign out_valid = main_valid;
   assign out_data  = main_data;
   assign occupancy = occ;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_elastic_pipe_stage.sv
// Bench for elastic_pipe_stage: skid and non-skid instances with scoreboards.
module tb_elastic_pipe_stage;

   localparam int DW = 136;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic reset;

   logic          s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
   logic [DW-1:0] s_in_data, s_out_data;
   logic [1:0]    s_occ;
   logic [CW-1:0] s_stall;

   logic          n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
   logic [DW-1:0] n_in_data, n_out_data;
   logic [1:0]    n_occ;
   logic [CW-1:0] n_stall;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] s_q[$];
   logic [DW-1:0] n_q[$];

   always #5 clk = ~clk;

   elastic_pipe_stage #(.DATA_W(DW), .SKID(1), .CNT_W(CW)) u_skid (
      .clk(clk), .reset(reset), .flush(s_flush),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
      .occupancy(s_occ), .stall_cnt(s_stall)
   );

   elastic_pipe_stage #(.DATA_W(DW), .SKID(0), .CNT_W(CW)) u_noskid (
      .clk(clk), .reset(reset), .flush(n_flush),
      .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
      .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
      .occupancy(n_occ), .stall_cnt(n_stall)
   );

   // Scoreboards: pop/compare on out_fire, push on in_fire, drop on flush/reset.
   always @(posedge clk) begin
      if (reset || s_flush) begin
         s_q.delete();
      end else begin
         if (s_out_valid && s_out_ready) begin
            checks++;
            if (s_q.size() == 0) begin
               errors++;
               $display("FAIL sb_skid_underflow got %0h", s_out_data);
            end else begin
               if (s_out_data !== s_q[0]) begin
                  errors++;
                  $display("FAIL sb_skid_order got %0h exp %0h", s_out_data, s_q[0]);
               end
               void'(s_q.pop_front());
            end
         end
         if (s_in_valid && s_in_ready) s_q.push_back(s_in_data);
      end
   end

   always @(posedge clk) begin
      if (reset || n_flush) begin
         n_q.delete();
      end else begin
         if (n_out_valid && n_out_ready) begin
            checks++;
            if (n_q.size() == 0) begin
               errors++;
               $display("FAIL sb_noskid_underflow got %0h", n_out_data);
            end else begin
               if (n_out_data !== n_q[0]) begin
                  errors++;
                  $display("FAIL sb_noskid_order got %0h exp %0h", n_out_data, n_q[0]);
               end
               void'(n_q.pop_front());
            end
         end
         if (n_in_valid && n_in_ready) n_q.push_back(n_in_data);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      s_in_valid = 1'b1; s_in_data = 136'h55; s_out_ready = 1'b0;
      n_in_valid = 1'b1; n_in_data = 136'h66; n_out_ready = 1'b0;
      repeat (3) tick();
      checks++;
      if (s_out_valid !== 1'b0 || s_out_data !== '0 || s_occ !== 2'd0 || s_stall !== '0) begin
         errors++;
         $display("FAIL reset_skid v=%b d=%0h occ=%0d st=%0d exp 0", s_out_valid, s_out_data, s_occ, s_stall);
      end
      checks++;
      if (n_out_valid !== 1'b0 || n_out_data !== '0 || n_occ !== 2'd0 || n_stall !== '0) begin
         errors++;
         $display("FAIL reset_noskid v=%b d=%0h occ=%0d st=%0d exp 0", n_out_valid, n_out_data, n_occ, n_stall);
      end
      reset = 1'b0;
      s_in_valid = 1'b0; n_in_valid = 1'b0;
      tick();
      checks++;
      if (s_in_ready !== 1'b1 || n_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b/%b exp 1/1", s_in_ready, n_in_ready);
      end
   endtask

   task automatic test_stream;
      s_out_ready = 1'b1; n_out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         s_in_valid = 1'b1; s_in_data = DW'(i);
         n_in_valid = 1'b1; n_in_data = DW'(i + 100);
         tick();
         checks++;
         if (s_out_data !== DW'(i) || s_occ !== 2'd1 || s_in_ready !== 1'b1 || s_stall !== '0) begin
            errors++;
            $display("FAIL stream_skid d=%0h occ=%0d rdy=%b st=%0d exp %0h 1 1 0", s_out_data, s_occ, s_in_ready, s_stall, i);
         end
         checks++;
         if (n_out_data !== DW'(i + 100) || n_occ !== 2'd1 || n_in_ready !== 1'b1 || n_stall !== '0) begin
            errors++;
            $display("FAIL stream_noskid d=%0h occ=%0d rdy=%b st=%0d exp %0h 1 1 0", n_out_data, n_occ, n_in_ready, n_stall, i + 100);
         end
      end
      s_in_valid = 1'b0; s_in_data = 'x;
      n_in_valid = 1'b0; n_in_data = 'x;
      tick();
      checks++;
      if (s_occ !== 2'd0 || n_occ !== 2'd0 || s_out_data !== '0 || n_out_data !== '0) begin
         errors++;
         $display("FAIL stream_drain occ=%0d/%0d d=%0h/%0h exp 0", s_occ, n_occ, s_out_data, n_out_data);
      end
   endtask

   task automatic test_skid_fill;
      s_in_valid = 1'b1; s_in_data = 136'hA; s_out_ready = 1'b1;
      tick();
      s_in_data = 136'hB; s_out_ready = 1'b0;
      tick();
      checks++;
      if (s_occ !== 2'd2 || s_in_ready !== 1'b0 || s_out_data !== 136'hA) begin
         errors++;
         $display("FAIL skid_full occ=%0d rdy=%b d=%0h exp 2 0 a", s_occ, s_in_ready, s_out_data);
      end
      s_in_data = 136'hC;
      tick();
      tick();
      checks++;
      if (s_occ !== 2'd2 || s_in_ready !== 1'b0 || s_out_data !== 136'hA || s_stall !== 4'd3) begin
         errors++;
         $display("FAIL skid_hold occ=%0d rdy=%b d=%0h st=%0d exp 2 0 a 3", s_occ, s_in_ready, s_out_data, s_stall);
      end
      s_out_ready = 1'b1;
      tick();
      checks++;
      if (s_out_data !== 136'hB || s_occ !== 2'd1 || s_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL skid_release d=%0h occ=%0d rdy=%b exp b 1 1", s_out_data, s_occ, s_in_ready);
      end
      tick();
      checks++;
      if (s_out_data !== 136'hC || s_occ !== 2'd1) begin
         errors++;
         $display("FAIL skid_third d=%0h occ=%0d exp c 1", s_out_data, s_occ);
      end
      s_in_valid = 1'b0; s_in_data = 'x;
      tick();
      checks++;
      if (s_out_valid !== 1'b0 || s_occ !== 2'd0 || s_out_data !== '0) begin
         errors++;
         $display("FAIL skid_empty v=%b occ=%0d d=%0h exp 0 0 0", s_out_valid, s_occ, s_out_data);
      end
   endtask

   task automatic test_flush;
      s_out_ready = 1'b0;
      s_in_valid = 1'b1; s_in_data = 136'h21;
      tick();
      s_in_data = 136'h22;
      tick();
      checks++;
      if (s_occ !== 2'd2 || s_stall !== 4'd4) begin
         errors++;
         $display("FAIL flush_prefill occ=%0d st=%0d exp 2 4", s_occ, s_stall);
      end
      s_flush = 1'b1; s_in_data = 136'hD;
      tick();
      checks++;
      if (s_out_valid !== 1'b0 || s_out_data !== '0 || s_occ !== 2'd0 || s_stall !== 4'd5) begin
         errors++;
         $display("FAIL flush_full v=%b d=%0h occ=%0d st=%0d exp 0 0 0 5", s_out_valid, s_out_data, s_occ, s_stall);
      end
      s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = 'x;
      tick();
      checks++;
      if (s_out_valid !== 1'b0 || s_occ !== 2'd0 || s_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_no_d v=%b occ=%0d rdy=%b exp 0 0 1", s_out_valid, s_occ, s_in_ready);
      end
      s_out_ready = 1'b1;
      s_in_valid = 1'b1; s_in_data = 136'h31;
      tick();
      s_flush = 1'b1; s_in_data = 136'h32;
      tick();
      s_flush = 1'b0; s_in_valid = 1'b0;
      checks++;
      if (s_out_valid !== 1'b0 || s_occ !== 2'd0 || s_stall !== 4'd5) begin
         errors++;
         $display("FAIL flush_half_drop v=%b occ=%0d st=%0d exp 0 0 5", s_out_valid, s_occ, s_stall);
      end
      tick();
      checks++;
      if (s_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_empty_noop v=%b exp 0", s_out_valid);
      end
   endtask

   task automatic test_stall_sat;
      logic [CW-1:0] exp_st;
      exp_st = s_stall;
      s_out_ready = 1'b0;
      s_in_valid = 1'b1; s_in_data = 136'h41;
      tick();
      s_in_valid = 1'b0; s_in_data = 'x;
      for (int i = 0; i < (1 << CW) + 5; i++) begin
         tick();
         exp_st = (exp_st == 4'd15) ? exp_st : exp_st + 4'd1;
         checks++;
         if (s_stall !== exp_st) begin
            errors++;
            $display("FAIL stall_count cyc=%0d got %0d exp %0d", i, s_stall, exp_st);
         end
      end
      s_out_ready = 1'b1;
      tick();
      checks++;
      if (s_stall !== 4'd15 || s_occ !== 2'd0) begin
         errors++;
         $display("FAIL stall_sticky st=%0d occ=%0d exp 15 0", s_stall, s_occ);
      end
   endtask

   task automatic test_noskid;
      n_in_valid = 1'b1; n_in_data = 136'h51; n_out_ready = 1'b1;
      tick();
      n_out_ready = 1'b0; n_in_data = 136'h52;
      #1;
      checks++;
      if (n_in_ready !== 1'b0) begin
         errors++;
         $display("FAIL noskid_ready_comb got %b exp 0", n_in_ready);
      end
      tick();
      checks++;
      if (n_out_data !== 136'h51 || n_occ !== 2'd1) begin
         errors++;
         $display("FAIL noskid_hold d=%0h occ=%0d exp 51 1", n_out_data, n_occ);
      end
      n_out_ready = 1'b1;
      #1;
      checks++;
      if (n_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL noskid_ready_rise got %b exp 1", n_in_ready);
      end
      tick();
      checks++;
      if (n_out_data !== 136'h52 || n_occ !== 2'd1 || n_stall !== 4'd1) begin
         errors++;
         $display("FAIL noskid_replace d=%0h occ=%0d st=%0d exp 52 1 1", n_out_data, n_occ, n_stall);
      end
      n_out_ready = 1'b0; n_flush = 1'b1; n_in_data = 136'h54;
      tick();
      n_flush = 1'b0; n_in_valid = 1'b0; n_in_data = 'x;
      checks++;
      if (n_out_valid !== 1'b0 || n_out_data !== '0 || n_occ !== 2'd0) begin
         errors++;
         $display("FAIL noskid_flush v=%b d=%0h occ=%0d exp 0 0 0", n_out_valid, n_out_data, n_occ);
      end
      tick();
   endtask

   task automatic test_final;
      checks++;
      if (s_q.size() != 0 || n_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover got %0d/%0d exp 0/0", s_q.size(), n_q.size());
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      checks++;
      if (s_stall !== '0 || s_occ !== 2'd0) begin
         errors++;
         $display("FAIL reset_clears_stall st=%0d occ=%0d exp 0 0", s_stall, s_occ);
      end
   endtask

   initial begin
      reset = 1'b1;
      s_flush = 1'b0; n_flush = 1'b0;
      s_in_valid = 1'b0; n_in_valid = 1'b0;
      s_in_data = '0; n_in_data = '0;
      s_out_ready = 1'b0; n_out_ready = 1'b0;
      #1;
      test_reset();
      test_stream();
      test_skid_fill();
      test_flush();
      test_stall_sat();
      test_noskid();
      test_final();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
